pc_ctrl: RTL and testbench

- Program-counter sequencer for the pico core; consumes the decoder's PC mode, halt and wait-for-interrupt strobes.
- Owns the PC register, a hardware return-address stack for JSBR/RSBR, and the RUN/WAIT/HALT core state machine.
- run_o gates the core's instruction fetch and register-file write enable.

---
 rtl/pc_ctrl.sv | 131 +++++++++++++
 tb/tb_pc_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter sequencer for the pico core.
// Holds the PC, a small return-address stack and the RUN/WAIT/HALT state machine.
module pc_ctrl #(
    parameter int PC_W        = 8,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mode_pc_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [PC_W-1:0]  target_i,
    input  logic             halt_core_i,
    input  logic             wfi_core_i,
    input  logic             ext_int_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             run_o,
    output logic             waiting_o,
    output logic             halted_o,
    output logic             stack_ovf_o,
    output logic             stack_unf_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int EXT_W = (PC_W > OFF_W) ? PC_W : OFF_W;

    typedef enum logic [1:0] {MODE_INC, MODE_REL, MODE_SUB, MODE_RET} mode_t;
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W:0]   sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push;

    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [EXT_W-1:0] off_ext;
    logic [SP_W-1:0]  sp_top;
    logic             stack_full;
    logic             stack_empty;

    assign pc_inc      = pc_q + PC_W'(1);
    assign off_ext     = EXT_W'($signed(offset_i));
    // Top-of-stack index; wraps correctly when the stack is full.
    assign sp_top      = sp_q[SP_W-1:0] - SP_W'(1);
    assign stack_full  = (sp_q == (SP_W+1)'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_core_i) begin
                    state_d = ST_HALT;
                end else if (wfi_core_i) begin
                    state_d = ST_WAIT;
                end else begin
                    case (mode_pc_i)
                        MODE_INC: pc_d = pc_inc;
                        MODE_REL: pc_d = pc_q + off_ext[PC_W-1:0];
                        MODE_SUB: begin
                            if (stack_full) begin
                                ovf_d   = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + (SP_W+1)'(1);
                                pc_d = target_i;
                            end
                        end
                        default: begin
                            if (stack_empty) begin
                                pc_d  = '0;
                                unf_d = 1'b1;
                            end else begin
                                sp_d = sp_q - (SP_W+1)'(1);
                                pc_d = stack_q[sp_top];
                            end
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (ext_int_i) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are don't-care after reset; only the pointer is cleared.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            stack_q[sp_q[SP_W-1:0]] <= pc_inc;
        end
    end

    assign pc_o        = pc_q;
    assign run_o       = (state_q == ST_RUN);
    assign waiting_o   = (state_q == ST_WAIT);
    assign halted_o    = (state_q == ST_HALT);
    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus pushes model predictions, a monitor pops and checks.
module tb_pc_ctrl;

    localparam int PC_W  = 8;
    localparam int OFF_W = 8;
    localparam int DEPTH = 4;

    localparam logic [1:0] INC = 2'd0, REL = 2'd1, SUB = 2'd2, RET = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  target;
    logic             halt_core, wfi_core, ext_int;
    logic [PC_W-1:0]  pc;
    logic             run, waiting, halted, ovf, unf;

    pc_ctrl #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mode_pc_i  (mode),
        .offset_i   (offset),
        .target_i   (target),
        .halt_core_i(halt_core),
        .wfi_core_i (wfi_core),
        .ext_int_i  (ext_int),
        .pc_o       (pc),
        .run_o      (run),
        .waiting_o  (waiting),
        .halted_o   (halted),
        .stack_ovf_o(ovf),
        .stack_unf_o(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit run, wait_s, halt, ovf, unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    // Reference model: state 0=RUN 1=WAIT 2=HALT, stack as a plain queue.
    int m_pc = 0, m_st = 0;
    bit m_ovf = 0, m_unf = 0;
    int m_stk[$];

    task automatic step(input bit r, input logic [1:0] md, input logic [7:0] off,
                        input logic [7:0] tgt, input bit h, input bit w, input bit e);
        exp_t x;
        @(negedge clk);
        rst = r; mode = md; offset = off; target = tgt;
        halt_core = h; wfi_core = w; ext_int = e;
        if (r) begin
            m_pc = 0; m_st = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
        end else if (m_st == 0) begin
            if (h) m_st = 2;
            else if (w) m_st = 1;
            else if (md == INC) m_pc = (m_pc + 1) % 256;
            else if (md == REL) m_pc = (m_pc + int'($signed(off))) & 255;
            else if (md == SUB) begin
                if (m_stk.size() == DEPTH) begin m_ovf = 1; m_st = 2; end
                else begin m_stk.push_back((m_pc + 1) % 256); m_pc = int'(tgt); end
            end else begin
                if (m_stk.size() == 0) begin m_pc = 0; m_unf = 1; end
                else m_pc = m_stk.pop_back();
            end
        end else if (m_st == 1) begin
            if (e) begin m_pc = (m_pc + 1) % 256; m_st = 0; end
        end
        x.pc = m_pc; x.run = (m_st == 0); x.wait_s = (m_st == 1); x.halt = (m_st == 2);
        x.ovf = m_ovf; x.unf = m_unf;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, req);
        end
    endtask

    // Monitor: outputs settle after each rising edge; one prediction per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d pc=%0d run=%0b wait=%0b halt=%0b ovf=%0b unf=%0b",
                         txn, pc, run, waiting, halted, ovf, unf);
                chk("pc", int'(pc), e.pc);
                chk("run", int'(run), int'(e.run));
                chk("waiting", int'(waiting), int'(e.wait_s));
                chk("halted", int'(halted), int'(e.halt));
                chk("stack_ovf", int'(ovf), int'(e.ovf));
                chk("stack_unf", int'(unf), int'(e.unf));
            end
        end
    end

    initial begin
        rst = 1; mode = INC; offset = '0; target = '0;
        halt_core = 0; wfi_core = 0; ext_int = 0;

        // Increment from reset, then wrap at 255.
        step(1, INC, 0, 0, 0, 0, 0);
        repeat (3) step(0, INC, 0, 0, 0, 0, 0);
        step(1, INC, 0, 0, 0, 0, 0);
        step(0, REL, 8'hFF, 0, 0, 0, 0);
        step(0, INC, 0, 0, 0, 0, 0);

        // Relative branches both directions, and zero offset.
        step(1, INC, 0, 0, 0, 0, 0);
        step(0, REL, 8'd10, 0, 0, 0, 0);
        step(0, REL, 8'hFC, 0, 0, 0, 0);
        step(0, REL, 8'h05, 0, 0, 0, 0);
        step(0, REL, 8'h00, 0, 0, 0, 0);

        // Nested calls and returns.
        step(1, INC, 0, 0, 0, 0, 0);
        step(0, REL, 8'd3, 0, 0, 0, 0);
        step(0, SUB, 0, 8'h40, 0, 0, 0);
        step(0, INC, 0, 0, 0, 0, 0);
        step(0, SUB, 0, 8'h80, 0, 0, 0);
        step(0, RET, 0, 0, 0, 0, 0);
        step(0, RET, 0, 0, 0, 0, 0);

        // Overflow halts; interrupt ignored in HALT; reset recovers.
        step(1, INC, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, SUB, 0, 8'(16 * i + 5), 0, 0, 0);
        step(0, SUB, 0, 8'hAA, 0, 0, 0);
        step(0, INC, 0, 0, 0, 0, 1);
        step(0, RET, 0, 0, 0, 1, 1);
        step(1, INC, 0, 0, 0, 0, 0);

        // Underflow.
        step(0, RET, 0, 0, 0, 0, 0);
        step(0, INC, 0, 0, 0, 0, 0);

        // WAIT then wake; halt beats wfi.
        step(1, INC, 0, 0, 0, 0, 0);
        step(0, REL, 8'd7, 0, 0, 0, 0);
        step(0, INC, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, REL, 8'd5, 0, i[0], 1, 0);
        step(0, SUB, 0, 8'h33, 0, 0, 1);
        step(0, INC, 0, 0, 1, 1, 0);
        step(0, INC, 0, 0, 0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
                 8'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
